// File: rtl/counter_sequencer_pkg.sv
// rtl/counter_sequencer_pkg.sv - shared state/mode encodings and default widths for counter_sequencer
package counter_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_EVW   = 8;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

endpackage

// File: rtl/counter_sequencer_term.sv
// rtl/counter_sequencer_term.sv - terminal-value detect (all-ones going up, zero going down)
module counter_sequencer_term #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cnt_do_i,
    input  logic             dir_up_i,
    output logic             term_o
);

    assign term_o = dir_up_i ? (cnt_do_i == {WIDTH{1'b1}}) : (cnt_do_i == {WIDTH{1'b0}});

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - up/down/ping-pong sweep controller for the 8-bit counter; CARRY_CHECK_EN adds the carry-out checker
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int EVW   = DEFAULT_EVW
) (
    input  logic             clk,
    input  logic             RES,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] start_val,
    input  logic [EVW-1:0]   repeat_cnt,
    input  logic             abort,
    output logic             cnt_RES,
    output logic             cnt_EN,
    output logic             cnt_PL,
    output logic [WIDTH-1:0] cnt_di,
    output logic             cnt_INC,
    output logic             cnt_DEC,
    output logic             cnt_CarryIn,
    input  logic             cnt_CarryOut,
    input  logic [WIDTH-1:0] cnt_do,
    output logic             busy,
    output logic             done,
    output logic [EVW-1:0]   events,
    output logic             err
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] start_val_q, start_val_d;
    logic [EVW-1:0]   repeat_q, repeat_d;
    logic [EVW-1:0]   events_q, events_d;
    logic             dir_up_q, dir_up_d;

    logic             term;
    logic             pingpong;
    logic             up_cmd;
    logic [EVW-1:0]   events_inc;
    logic             stop_hit;

    counter_sequencer_term #(.WIDTH(WIDTH)) u_term (
        .cnt_do_i (cnt_do),
        .dir_up_i (dir_up_q),
        .term_o   (term)
    );

    assign pingpong   = (mode_q == MODE_PP);
    // A ping-pong bounce drives the reversed direction on the terminal cycle itself
    assign up_cmd     = (pingpong && term) ? !dir_up_q : dir_up_q;
    assign events_inc = (events_q == {EVW{1'b1}}) ? events_q : events_q + EVW'(1);
    assign stop_hit   = (repeat_q != '0) && (events_inc == repeat_q);

    always_ff @(posedge clk) begin
        if (RES) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_UP;
            start_val_q <= '0;
            repeat_q    <= '0;
            events_q    <= '0;
            dir_up_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            start_val_q <= start_val_d;
            repeat_q    <= repeat_d;
            events_q    <= events_d;
            dir_up_q    <= dir_up_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = abort ? ST_CLEAR : ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (term && stop_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        start_val_d = start_val_q;
        repeat_d    = repeat_q;
        events_d    = events_q;
        dir_up_d    = dir_up_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Reserved mode 11 is folded into UP at latch time
                    mode_d      = (mode == MODE_DOWN || mode == MODE_PP) ? mode : MODE_UP;
                    start_val_d = start_val;
                    repeat_d    = repeat_cnt;
                    events_d    = '0;
                    dir_up_d    = (mode != MODE_DOWN);
                end
            end
            ST_RUN: begin
                if (term) begin
                    events_d = events_inc;
                    if (pingpong) dir_up_d = !dir_up_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_RES     = RES;
        cnt_EN      = 1'b0;
        cnt_PL      = 1'b0;
        cnt_di      = '0;
        cnt_INC     = 1'b0;
        cnt_DEC     = 1'b0;
        cnt_CarryIn = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        if (!RES) begin
            case (state_q)
                ST_LOAD: begin
                    cnt_EN = 1'b1;
                    cnt_PL = 1'b1;
                    cnt_di = start_val_q;
                    busy   = 1'b1;
                end
                ST_RUN: begin
                    cnt_EN      = 1'b1;
                    cnt_CarryIn = 1'b0;
                    cnt_INC     = up_cmd;
                    cnt_DEC     = !up_cmd;
                    busy        = 1'b1;
                end
                ST_DONE: begin
                    done = 1'b1;
                    busy = 1'b1;
                end
                ST_CLEAR: cnt_RES = 1'b1;
                default: ;
            endcase
        end
    end

    assign events = events_q;

`ifdef CARRY_CHECK_EN
    logic err_q, err_d;

    // Ping-pong never commands a wrap, so carry-out is only meaningful in UP/DOWN
    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            err_d = 1'b0;
        end else if (state_q == ST_RUN && !pingpong && (cnt_CarryOut != term)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RES) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic carry_unused;
    assign carry_unused = cnt_CarryOut;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - self-checking bench for counter_sequencer with a behavioural 8-bit counter
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       RES;
    logic       start;
    logic [1:0] mode_r;
    logic [7:0] start_val;
    logic [7:0] repeat_cnt;
    logic       abort;
    logic       cnt_RES, cnt_EN, cnt_PL, cnt_INC, cnt_DEC, cnt_CarryIn, cnt_CarryOut;
    logic [7:0] cnt_di, cnt_do;
    logic       busy, done, err;
    logic [7:0] events;

    always #5 clk = ~clk;

    counter_sequencer dut (
        .clk          (clk),
        .RES          (RES),
        .start        (start),
        .mode         (mode_r),
        .start_val    (start_val),
        .repeat_cnt   (repeat_cnt),
        .abort        (abort),
        .cnt_RES      (cnt_RES),
        .cnt_EN       (cnt_EN),
        .cnt_PL       (cnt_PL),
        .cnt_di       (cnt_di),
        .cnt_INC      (cnt_INC),
        .cnt_DEC      (cnt_DEC),
        .cnt_CarryIn  (cnt_CarryIn),
        .cnt_CarryOut (cnt_CarryOut),
        .cnt_do       (cnt_do),
        .busy         (busy),
        .done         (done),
        .events       (events),
        .err          (err)
    );

    // Behavioural counter: clears on RES, holds without EN, loads on PL, counts with CarryIn low
    logic [7:0] cnt_q = 8'h00;
    logic       co_kill = 1'b0;
    always @(posedge clk) begin
        if (cnt_RES) cnt_q <= 8'h00;
        else if (cnt_EN) begin
            if (cnt_PL) cnt_q <= cnt_di;
            else if (!cnt_CarryIn && cnt_INC) cnt_q <= cnt_q + 8'd1;
            else if (!cnt_CarryIn && cnt_DEC) cnt_q <= cnt_q - 8'd1;
        end
    end
    assign cnt_do       = cnt_q;
    assign cnt_CarryOut = !co_kill && cnt_EN && !cnt_CarryIn &&
                          ((cnt_INC && cnt_q == 8'hFF) || (cnt_DEC && cnt_q == 8'h00));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the counter value by the sweep rules until repeat events are seen
    logic [7:0] exp_seq[$];
    logic [7:0] exp_fin;
    int         exp_ev;

    task automatic model(input logic [1:0] m, input logic [7:0] sv, input logic [7:0] rep);
        logic       up;
        logic [7:0] v;
        up = (m != 2'b01);
        v  = sv;
        exp_ev = 0;
        exp_seq.delete();
        while (exp_ev < int'(rep)) begin
            exp_seq.push_back(v);
            if (up ? (v == 8'hFF) : (v == 8'h00)) begin
                exp_ev++;
                if (m == 2'b10) up = !up;
            end
            v = up ? v + 8'd1 : v - 8'd1;
        end
        exp_fin = v;
    endtask

    task automatic do_run(input logic [1:0] m, input logic [7:0] sv, input logic [7:0] rep,
                          output int cyc, output logic [7:0] fin, output logic [7:0] ev,
                          output int co, output int seq_bad, output int out_bad);
        int got;
        int i;
        @(negedge clk);
        mode_r = m; start_val = sv; repeat_cnt = rep; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_ctl", {cnt_EN, cnt_PL, busy, cnt_INC, cnt_DEC}, 5'b11100);
        check("load_di", cnt_di, sv);
        cyc = 0; co = 0; seq_bad = 0; out_bad = 0; fin = 8'h00; ev = 8'h00;
        got = 0; i = 0;
        while (got == 0 && i < 1500) begin
            @(negedge clk);
            if (done) begin
                got = 1; fin = cnt_do; ev = events;
            end else begin
                if (cyc >= exp_seq.size() || cnt_do !== exp_seq[cyc]) seq_bad++;
                if (cnt_CarryOut) co++;
                if (!(cnt_EN && !cnt_CarryIn && !cnt_PL && (cnt_INC ^ cnt_DEC) && busy)) out_bad++;
                cyc++;
            end
            i++;
        end
        check("done_seen", got, 1);
        @(negedge clk);
        check("done_1cyc", {done, busy}, 2'b00);
    endtask

    typedef struct {
        logic [1:0] m;
        logic [7:0] sv;
        logic [7:0] rep;
        int         cyc;
        logic [7:0] fin;
        logic [7:0] ev;
        int         co;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, co, sb, ob, dseen;
        logic [7:0] fin, ev;
        logic exp_err;

        tbl[0] = '{2'b00, 8'hFE, 8'd2, 258, 8'h00, 8'd2, 2};
        tbl[1] = '{2'b01, 8'h01, 8'd1, 2,   8'hFF, 8'd1, 1};
        tbl[2] = '{2'b10, 8'hFD, 8'd2, 258, 8'h01, 8'd2, 0};
        tbl[3] = '{2'b11, 8'hFF, 8'd1, 1,   8'h00, 8'd1, 1};
        tbl[4] = '{2'b01, 8'h00, 8'd1, 1,   8'hFF, 8'd1, 1};
        tbl[5] = '{2'b10, 8'h00, 8'd1, 256, 8'hFE, 8'd1, 0};
        tbl[6] = '{2'b10, 8'hFF, 8'd1, 1,   8'hFE, 8'd1, 0};
        tbl[7] = '{2'b01, 8'h80, 8'd2, 385, 8'hFF, 8'd2, 2};

        RES = 1'b1; start = 1'b0; abort = 1'b0; mode_r = 2'b00; start_val = 8'h00; repeat_cnt = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ctl", {cnt_RES, cnt_EN, cnt_PL, cnt_INC, cnt_DEC, cnt_CarryIn}, 6'b100001);
        check("rst_flags", {busy, done, cnt_di}, 10'h000);
        RES = 1'b0;
        @(negedge clk);
        check("rst_state", {events, err, busy, cnt_RES, cnt_do}, 19'h0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort", {cnt_RES, busy}, 2'b00);

        for (int k = 0; k < 8; k++) begin
            model(tbl[k].m, tbl[k].sv, tbl[k].rep);
            do_run(tbl[k].m, tbl[k].sv, tbl[k].rep, cyc, fin, ev, co, sb, ob);
            check($sformatf("tbl%0d_cyc", k), cyc, tbl[k].cyc);
            check($sformatf("tbl%0d_fin", k), fin, tbl[k].fin);
            check($sformatf("tbl%0d_ev", k), ev, tbl[k].ev);
            check($sformatf("tbl%0d_co", k), co, tbl[k].co);
            check($sformatf("tbl%0d_seq", k), sb, 0);
            check($sformatf("tbl%0d_outs", k), ob, 0);
            check($sformatf("tbl%0d_err", k), err, 1'b0);
        end

        for (int k = 0; k < 12; k++) begin
            logic [1:0] m;
            logic [7:0] sv, rep;
            m   = 2'($urandom_range(0, 3));
            sv  = 8'($urandom);
            rep = 8'($urandom_range(1, 3));
            model(m, sv, rep);
            do_run(m, sv, rep, cyc, fin, ev, co, sb, ob);
            check($sformatf("rnd%0d_cyc", k), cyc, exp_seq.size());
            check($sformatf("rnd%0d_fin", k), fin, exp_fin);
            check($sformatf("rnd%0d_ev", k), ev, exp_ev);
            check($sformatf("rnd%0d_co", k), co, (m == 2'b10) ? 0 : exp_ev);
            check($sformatf("rnd%0d_seq", k), sb, 0);
            check($sformatf("rnd%0d_outs", k), ob, 0);
        end

        // start during RUN is ignored: DOWN 05 repeat 1 still takes 6 RUN cycles and ends at FF
        @(negedge clk);
        mode_r = 2'b01; start_val = 8'h05; repeat_cnt = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; dseen = 0;
        for (int i = 0; i < 40 && dseen == 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dseen = 1; fin = cnt_do;
            end else begin
                cyc++;
                if (cyc == 2) begin
                    mode_r = 2'b00; start_val = 8'h00; repeat_cnt = 8'd5; start = 1'b1;
                end
            end
        end
        check("busy_start_done", dseen, 1);
        check("busy_start_cyc", cyc, 6);
        check("busy_start_fin", fin, 8'hFF);

        // abort on the final-event cycle wins over done
        @(negedge clk);
        mode_r = 2'b00; start_val = 8'hFF; repeat_cnt = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_last_do", cnt_do, 8'hFF);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_last_clear", {cnt_RES, done, busy}, 3'b100);
        @(negedge clk);
        check("abort_last_idle", {cnt_RES, done, busy, cnt_do}, 11'h0);

        // RES mid-RUN
        @(negedge clk);
        mode_r = 2'b00; start_val = 8'hFE; repeat_cnt = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("res_pre_ev", events, 8'd1);
        RES = 1'b1;
        #1;
        check("res_comb", {cnt_RES, cnt_EN, cnt_CarryIn, cnt_INC, cnt_DEC}, 5'b10100);
        @(negedge clk);
        RES = 1'b0;
        #1;
        check("res_after", {busy, cnt_do, events, cnt_CarryIn}, 18'h1);

        // Carry-out checker: suppress CarryOut through an UP wrap
        co_kill = 1'b1;
        model(2'b00, 8'hFD, 8'd1);
        do_run(2'b00, 8'hFD, 8'd1, cyc, fin, ev, co, sb, ob);
        co_kill = 1'b0;
`ifdef CARRY_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("err_set", err, exp_err);
        @(negedge clk);
        check("err_sticky", err, exp_err);
        model(2'b00, 8'hFF, 8'd1);
        do_run(2'b00, 8'hFF, 8'd1, cyc, fin, ev, co, sb, ob);
        check("err_cleared", err, 1'b0);

        // repeat=0 from 00: events saturate, then abort clears the counter and keeps events
        @(negedge clk);
        mode_r = 2'b00; start_val = 8'h00; repeat_cnt = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dseen = 0;
        for (int n = 1; n <= 65600; n++) begin
            @(negedge clk);
            if (done) dseen = 1;
            if (n == 1000) check("sat_mid_ev", events, 8'd3);
        end
        check("sat_ev", events, 8'hFF);
        check("sat_nodone", {dseen[0], busy}, 2'b01);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("sat_clear", {cnt_RES, busy, done}, 3'b100);
        @(negedge clk);
        check("sat_idle", {cnt_RES, busy, done, cnt_do, events}, 19'h000FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Master-side controller for the 8-bit up/down counter's control interface (RES/EN/PL/di/INC/DEC/CarryIn, with CarryOut/do returned). It loads a start value, then sweeps the counter up, down or ping-pong. It counts terminal events (wraps or bounces) and stops after a programmed number of them. It sits between the control/register layer and a counter instance, and replaces hand-driven counter control.

Parameters:
WIDTH, 8, counter data width (cnt_di, cnt_do, start_val)
EVW, 8, width of repeat_cnt and events

Ports:
clk  input  1  system clock, all logic on posedge
RES  input  1  synchronous active-high reset
start  input  1  one-cycle request, sampled only in IDLE
mode  input  2  00=UP, 01=DOWN, 10=PINGPONG (starts up), 11=reserved, treated as UP
start_val  input  WIDTH  value parallel-loaded into the counter
repeat_cnt  input  EVW  terminal events before stop; 0 = run until abort
abort  input  1  stop and clear the counter
cnt_RES  output  1  counter reset
cnt_EN  output  1  counter enable
cnt_PL  output  1  counter parallel load
cnt_di  output  WIDTH  counter load data
cnt_INC  output  1  count up
cnt_DEC  output  1  count down
cnt_CarryIn  output  1  counter carry-in, active low (0 = count)
cnt_CarryOut  input  1  counter carry-out
cnt_do  input  WIDTH  counter value
busy  output  1  high from LOAD through DONE
done  output  1  one-cycle pulse on completion
events  output  EVW  terminal events in current/last run, saturating
err  output  1  sticky carry mismatch (optional feature only, else 0)

Behaviour:
- Clock and reset: one clock `clk`; reset `RES` is synchronous and active-high.
- Reset (RES=1 at posedge):
  - state=IDLE; events=0; err=0; dir=up.
  - cnt_RES follows RES combinationally, so the counter clears with this block.
  - All other cnt_* outputs are 0, except cnt_CarryIn=1.
  - busy=0, done=0.
- FSM states: IDLE, LOAD, RUN, DONE, CLEAR.
- IDLE:
  - Counter idle: cnt_EN=0, cnt_CarryIn=1.
  - On start, latch mode, start_val and repeat_cnt; clear events; set dir=up (DOWN mode: dir=down); go to LOAD.
  - abort in IDLE is ignored.
- LOAD (1 cycle): cnt_EN=1, cnt_PL=1, cnt_di=start_val, cnt_INC=cnt_DEC=0 -> RUN.
- RUN:
  - cnt_EN=1, cnt_CarryIn=0, cnt_PL=0.
  - Exactly one of cnt_INC/cnt_DEC is high every cycle.
- Terminal condition, combinational from cnt_do: term = (dir=up and cnt_do=all-ones) or (dir=down and cnt_do=0).
- UP/DOWN modes:
  - Direction is constant; the counter wraps on term (FF->00 or 00->FF).
  - A term cycle is one event.
- PINGPONG mode:
  - On a term cycle, the direction driven that same cycle is already the opposite one, and dir toggles at the edge.
  - The counter therefore bounces (FF->FE, 00->01) and never wraps; each bounce is one event.
- Event counting:
  - events increments at each posedge in RUN with term=1, saturating at all-ones.
  - If repeat_cnt!=0 and that increment reaches repeat_cnt, go to DONE.
  - The counter has already taken the wrapped/bounced step at that edge.
- DONE (1 cycle): cnt_EN=0 (counter holds); done=1; busy=1 -> IDLE.
- abort in LOAD or RUN -> CLEAR. CLEAR (1 cycle): cnt_RES=1 -> IDLE. No done pulse; events retained.
- Priority: RES > abort > terminal stop.
  - abort on the final-event cycle wins: CLEAR, no done.
- start while busy is ignored.
- start_val may equal the terminal value: the first RUN cycle is immediately an event.
- events and err persist in IDLE until the next start or RES.

Optional Feature:
CARRY_CHECK_EN defined:
- In RUN with mode UP/DOWN, each cycle compares cnt_CarryOut against term.
- Mismatch sets err (sticky until RES or next start). No effect on sequencing.
- PINGPONG: not checked. The counter raises CarryOut only when a wrap is commanded, which never happens in that mode.

Undefined: comparator absent; err tied 0.

Package / sub-module:
- Shared package: state encoding enum; mode encoding constants (MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PP=2'b10); the WIDTH default.
- No sub-module required. A small term_detect helper (cnt_do, dir -> term) may be factored out and reused by the checker.

Test Plan:
- UP, start_val=FE, repeat=2, start:
  - LOAD, then cnt_do FE, FF (event1), 00...FF (event2) -> 00.
  - done pulses 258 cycles after LOAD; events=2; final cnt_do=00.
- DOWN, start_val=01, repeat=1 -> cnt_do 01, 00, FF; done; events=1; cnt_CarryOut high exactly on the cnt_do=00 cycle.
- PINGPONG, start_val=FD, repeat=2:
  - cnt_do FD, FE, FF, FE, ..., 00, 01.
  - done after the second bounce; cnt_do never wraps; events=2.
- repeat=0, UP from 00:
  - Runs past 255 wraps; events saturates at FF.
  - abort -> CLEAR with cnt_RES=1 for one cycle; cnt_do=00; busy=0; no done.
- start pulsed during RUN is ignored. RES mid-RUN -> next cycle IDLE, cnt_do=00, events=0, cnt_CarryIn=1.
- CARRY_CHECK_EN: UP run with the bench forcing cnt_CarryOut=0 at FF -> err=1 and stays 1 until the next start. Macro undefined: err stays 0.
